exec_unit_pipe: RTL and testbench

- Parametrised, registered successor to the combinational execute stage.
- Performs LOAD/JMP immediate pass-through and ALU operations, including an iterative multi-cycle multiply.
- Places results in an output register with valid/ready handshakes on both sides.
- N/Z flags are registered and held when an instruction does not set them.
- Sits between decode/register-read and writeback in the CPU datapath.

---
 rtl/exec_unit_pipe_if.sv | 30 +++
 rtl/exec_unit_pipe.sv | 153 +++++++++++++++
 tb/tb_exec_unit_pipe.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_pipe_if.sv
// Handshake and data bundle between decode/register-read, the execute
// stage and writeback. The master side presents instructions and consumes
// results; the slave side is the execute unit.
interface exec_unit_pipe_if #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        opcode;
    logic [IMM_W-1:0]  operand;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              N;
    logic              Z;
    logic              busy;

    modport master (
        output in_valid, opcode, operand, read_data1, read_data2, out_ready,
        input  in_ready, out_valid, result, N, Z, busy
    );

    modport slave (
        input  in_valid, opcode, operand, read_data1, read_data2, out_ready,
        output in_ready, out_valid, result, N, Z, busy
    );
endinterface

// File: rtl/exec_unit_pipe.sv
// Registered execute stage: single-cycle ALU/immediate ops plus an
// iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle.
// Results and N/Z flags sit in an output register behind valid/ready.
module exec_unit_pipe #(
    parameter int DATA_W  = 16,
    parameter int IMM_W   = 12,
    parameter int MUL_BPC = 1
) (
    input  logic            clk,
    input  logic            reset,
    exec_unit_pipe_if.slave bus
);
    localparam int MUL_ITER = DATA_W / MUL_BPC;
    localparam int SH_W     = $clog2(DATA_W);
    localparam int CNT_W    = $clog2(MUL_ITER + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITER - 1);

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state_reg, state_next;
    logic              in_ready, busy, accept, mul_last;
    logic              out_valid_reg, n_reg, z_reg, sets_flags;
    logic [DATA_W-1:0] result_reg, alu_result;
    logic [DATA_W-1:0] mcand_reg, mplier_reg, acc_reg, mul_sum;
    logic [CNT_W-1:0]  iter_reg;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] pp [MUL_BPC];

    assign shamt    = bus.read_data2[SH_W-1:0];
    assign accept   = bus.in_valid && in_ready;
    assign mul_last = (state_reg == S_MUL) && (iter_reg == LAST_ITER);

    assign bus.in_ready  = in_ready;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.N         = n_reg;
    assign bus.Z         = z_reg;

    // State register; reset abandons any multiply in flight.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next state: enter MUL on an accepted multiply, leave on its last step.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept && bus.opcode == OP_MUL) state_next = S_MUL;
            S_MUL:   if (mul_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs: accept only when idle and the result slot frees up.
    always_comb begin
        busy     = (state_reg == S_MUL);
        in_ready = !reset && (state_reg == S_IDLE) && (!out_valid_reg || bus.out_ready);
    end

    // Single-cycle datapath and whether the op updates N/Z.
    always_comb begin
        alu_result = bus.read_data1;
        sets_flags = 1'b1;
        case (bus.opcode)
            OP_LOAD, OP_JMP: begin
                alu_result = {{(DATA_W-IMM_W){1'b0}}, bus.operand};
                sets_flags = 1'b0;
            end
            OP_ADD:  alu_result = bus.read_data1 + bus.read_data2;
            OP_SUB:  alu_result = bus.read_data1 - bus.read_data2;
            OP_AND:  alu_result = bus.read_data1 & bus.read_data2;
            OP_OR:   alu_result = bus.read_data1 | bus.read_data2;
            OP_XOR:  alu_result = bus.read_data1 ^ bus.read_data2;
            OP_SHL:  alu_result = bus.read_data1 << shamt;
            OP_SHR:  alu_result = bus.read_data1 >> shamt;
            OP_MUL:  alu_result = bus.read_data1;
            default: sets_flags = 1'b0;
        endcase
    end

    // Partial products for the low MUL_BPC multiplier bits of this step.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_BPC; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
        end
    endgenerate

    // Accumulator plus this step's partial products (low DATA_W bits only).
    always_comb begin
        mul_sum = acc_reg;
        for (int k = 0; k < MUL_BPC; k++) begin
            mul_sum = mul_sum + pp[k];
        end
    end

    // Output register, flags and multiplier iteration state.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            n_reg         <= 1'b0;
            z_reg         <= 1'b0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            iter_reg      <= '0;
        end else begin
            if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                if (bus.opcode == OP_MUL) begin
                    mcand_reg  <= bus.read_data1;
                    mplier_reg <= bus.read_data2;
                    acc_reg    <= '0;
                    iter_reg   <= '0;
                end else begin
                    result_reg    <= alu_result;
                    out_valid_reg <= 1'b1;
                    if (sets_flags) begin
                        n_reg <= alu_result[DATA_W-1];
                        z_reg <= (alu_result == '0);
                    end
                end
            end else if (state_reg == S_MUL) begin
                acc_reg    <= mul_sum;
                mcand_reg  <= mcand_reg << MUL_BPC;
                mplier_reg <= mplier_reg >> MUL_BPC;
                iter_reg   <= iter_reg + 1'b1;
                if (mul_last) begin
                    result_reg    <= mul_sum;
                    out_valid_reg <= 1'b1;
                    n_reg         <= mul_sum[DATA_W-1];
                    z_reg         <= (mul_sum == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_unit_pipe.sv
// Bench for exec_unit_pipe: directed scenarios plus randomized traffic with
// random backpressure. Accepted instructions push expected results into a
// scoreboard; an independent monitor pops and compares on every consume.
module tb_exec_unit_pipe;
    localparam int DATA_W   = 16;
    localparam int IMM_W    = 12;
    localparam int MUL_BPC  = 1;
    localparam int MUL_ITER = DATA_W / MUL_BPC;

    logic clk = 1'b0;
    logic reset;
    logic rand_phase = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exec_unit_pipe_if #(.DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();

    exec_unit_pipe #(.DATA_W(DATA_W), .IMM_W(IMM_W), .MUL_BPC(MUL_BPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] res;
        logic        n;
        logic        z;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on unsigned integers.
    function automatic logic [15:0] ref_result(input logic [3:0] op, input longint unsigned imm,
                                               input longint unsigned a, input longint unsigned b);
        longint unsigned r;
        longint unsigned sh;
        sh = b % 16;
        case (op)
            4'd0, 4'd7: r = imm;
            4'd1:       r = (a + b) % 65536;
            4'd2:       r = (a + 65536 - b) % 65536;
            4'd3:       r = a & b;
            4'd4:       r = a | b;
            4'd5:       r = a ^ b;
            4'd6:       r = (a * (64'd1 << sh)) % 65536;
            4'd9:       r = a / (64'd1 << sh);
            4'd8:       r = (a * b) % 65536;
            default:    r = a;
        endcase
        return 16'(r);
    endfunction

    function automatic bit sets_flags(input logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    endfunction

    // Issue side: every accept (sampled mid-cycle) pushes its expectation.
    initial begin : accept_mon
        logic        mdl_n;
        logic        mdl_z;
        logic [15:0] r;
        exp_t        e;
        mdl_n = 1'b0;
        mdl_z = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                mdl_n = 1'b0;
                mdl_z = 1'b0;
            end else if (bus.in_valid && bus.in_ready) begin
                r = ref_result(bus.opcode, longint'(bus.operand),
                               longint'(bus.read_data1), longint'(bus.read_data2));
                if (sets_flags(bus.opcode)) begin
                    mdl_n = r[15];
                    mdl_z = (r == 16'h0000);
                end
                e.res = r;
                e.n   = mdl_n;
                e.z   = mdl_z;
                sb_q.push_back(e);
            end
        end
    end

    // Result side: compare on every consume, and check output hold.
    initial begin : out_mon
        exp_t        e;
        logic [17:0] act;
        logic [17:0] held;
        logic        pend;
        pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            act = {bus.result, bus.N, bus.Z};
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("hold", 32'({bus.out_valid, act}), 32'({1'b1, held}));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        $display("txn result=%h N=%b Z=%b expect result=%h N=%b Z=%b",
                                 bus.result, bus.N, bus.Z, e.res, e.n, e.z);
                        check("txn", 32'(act), 32'({e.res, e.n, e.z}));
                    end
                end
                pend = bus.out_valid && !bus.out_ready;
                held = act;
            end
        end
    end

    // Random backpressure during the randomized phase.
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            if (rand_phase) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Call at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [11:0] imm,
                         input logic [15:0] a, input logic [15:0] b);
        bus.in_valid   = 1'b1;
        bus.opcode     = op;
        bus.operand    = imm;
        bus.read_data1 = a;
        bus.read_data2 = b;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (t > 200) begin
                check("accept_timeout", 32'(bus.in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin : stim
        int cnt;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.opcode     = 4'd0;
        bus.operand    = '0;
        bus.read_data1 = '0;
        bus.read_data2 = '0;
        bus.out_ready  = 1'b1;

        @(negedge clk);
        check("in_ready_during_reset", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_state", 32'({bus.out_valid, bus.result, bus.N, bus.Z, bus.busy}), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ADD to zero, SUB to negative, LOAD/JMP keep flags.
        issue(4'd1, 12'h000, 16'h0005, 16'hFFFB);
        @(negedge clk);
        check("add", 32'({bus.out_valid, bus.result, bus.N, bus.Z}), 32'({1'b1, 16'h0000, 1'b0, 1'b1}));
        @(posedge clk); #1;
        issue(4'd2, 12'h000, 16'h0003, 16'h0005);
        @(negedge clk);
        check("sub", 32'({bus.out_valid, bus.result, bus.N, bus.Z}), 32'({1'b1, 16'hFFFE, 1'b1, 1'b0}));
        @(posedge clk); #1;
        issue(4'd0, 12'hABC, 16'h0000, 16'h0000);
        @(negedge clk);
        check("load", 32'({bus.out_valid, bus.result, bus.N, bus.Z}), 32'({1'b1, 16'h0ABC, 1'b1, 1'b0}));
        @(posedge clk); #1;
        issue(4'd7, 12'h123, 16'h0000, 16'h0000);
        @(negedge clk);
        check("jmp", 32'({bus.out_valid, bus.result, bus.N, bus.Z}), 32'({1'b1, 16'h0123, 1'b1, 1'b0}));
        @(posedge clk); #1;

        // Multiply latency; inputs change under it and must be ignored.
        issue(4'd8, 12'h000, 16'h0012, 16'h0034);
        cnt = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            if (!bus.busy || bus.in_ready) check("mul_busy", 32'({bus.busy, bus.in_ready}), 32'b10);
            cnt++;
            bus.read_data1 = 16'($urandom);
            bus.read_data2 = 16'($urandom);
        end
        check("mul_latency", 32'(cnt), 32'(MUL_ITER));
        check("mul", 32'({bus.out_valid, bus.result, bus.N, bus.Z, bus.busy}),
              32'({1'b1, 16'h03A8, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;

        // Backpressure: result held, next instruction waits, then flows.
        bus.out_ready = 1'b0;
        issue(4'd1, 12'h000, 16'h0001, 16'h0002);
        bus.in_valid   = 1'b1;
        bus.opcode     = 4'd1;
        bus.read_data1 = 16'h0010;
        bus.read_data2 = 16'h0020;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("bp_stall", 32'({bus.in_ready, bus.out_valid, bus.result}), 32'({1'b0, 1'b1, 16'h0003}));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_new_result", 32'({bus.out_valid, bus.result}), 32'({1'b1, 16'h0030}));
        @(posedge clk); #1;

        // Reset five cycles into a multiply.
        issue(4'd8, 12'h000, 16'h1234, 16'h0077);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_mul_reset", 32'({bus.out_valid, bus.result, bus.N, bus.Z, bus.busy}), 32'd0);
        check("mid_mul_reset_ready", 32'(bus.in_ready), 32'd1);
        cnt = 0;
        for (int t = 0; t < MUL_ITER + 4; t++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("no_result_after_abort", 32'(cnt), 32'd0);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure.
        rand_phase = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int          sel;
            int          gap;
            logic [3:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            sel = $urandom_range(0, 19);
            op  = (sel < 16) ? 4'(sel) : ((sel < 18) ? 4'd1 : 4'd2);
            a   = 16'($urandom);
            b   = ($urandom_range(0, 5) == 0) ? a : 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'h0000;
            issue(op, 12'($urandom_range(0, 4095)), a, b);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        rand_phase = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !bus.out_valid) break;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
